scaled_divider: RTL and testbench

//   Sequential scale-and-divide unit: out = (register_value * decimal_two) / decimal_one.

---
 rtl/scaled_divider.sv | 142 ++++++++++++++
 tb/tb_scaled_divider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_divider.sv
// Sequential scale-and-divide: out = (register_value * decimal_two) / decimal_one, saturated.
// Latency: done pulses 2*WIDTH+2 edges after the start-sampling edge (2 edges if divisor is 0).
// Backpressure: none queued; start is only sampled in IDLE, ignored while busy.
module scaled_divider #(
    parameter int WIDTH = 16,
    parameter int ROUND = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] register_value,
    input  logic [WIDTH-1:0] decimal_two,
    input  logic [WIDTH-1:0] decimal_one,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, dv_q, dv_d;
    // Holds the product while dividing; quotient bits shift in at the LSB,
    // so after 2*WIDTH steps it holds the full quotient.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;

    logic [WIDTH:0]     rem_shift;
    logic               round_up;
    logic [2*WIDTH:0]   q_rnd;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dv_q    <= '0;
            work_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dv_q    <= dv_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state, restoring-division step, rounding and saturation
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        dv_d      = dv_q;
        work_d    = work_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        // Remainder stays below the divisor, so its low WIDTH bits suffice before the shift
        rem_shift = {rem_q[WIDTH-1:0], work_q[2*WIDTH-1]};
        round_up  = (ROUND != 0) && ({rem_q, 1'b0} >= {2'b00, dv_q});
        q_rnd     = {1'b0, work_q} + {{(2*WIDTH){1'b0}}, round_up};

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    a_d     = register_value;
                    b_d     = decimal_two;
                    dv_d    = decimal_one;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                work_d  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (dv_q == '0) ? S_DONE : S_DIV;
            end
            S_DIV: begin
                if (rem_shift >= {1'b0, dv_q}) begin
                    rem_d  = rem_shift - {1'b0, dv_q};
                    work_d = {work_q[2*WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    work_d = {work_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(2 * WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dv_q == '0) begin
                    out_d = '1;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else if (q_rnd[2*WIDTH:WIDTH] != '0) begin
                    out_d = '1;
                    ovf_d = 1'b1;
                    dz_d  = 1'b0;
                end else begin
                    out_d = q_rnd[WIDTH-1:0];
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign out      = out_q;
    assign ovf      = ovf_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_scaled_divider.sv
// Self-checking bench for scaled_divider: a truncating and a rounding instance share stimulus.
// Expected results come from plain integer arithmetic on the operands.
// Each scenario task drives its own stimulus and checks inline.
module tb_scaled_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rv = '0, d2 = '0, d1 = '0;
    logic        busy0, done0, ovf0, dz0, busy1, done1, ovf1, dz1;
    logic [15:0] out0, out1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scaled_divider #(.WIDTH(16), .ROUND(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .start(start),
        .register_value(rv), .decimal_two(d2), .decimal_one(d1),
        .busy(busy0), .done(done0), .out(out0), .ovf(ovf0), .div_zero(dz0)
    );

    scaled_divider #(.WIDTH(16), .ROUND(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start),
        .register_value(rv), .decimal_two(d2), .decimal_one(d1),
        .busy(busy1), .done(done1), .out(out1), .ovf(ovf1), .div_zero(dz1)
    );

    // Reference: exact product, integer quotient, optional half-up rounding, saturation
    function automatic void model(input logic [15:0] a, b, d, input int rnd,
                                  output logic [15:0] o, output logic v, output logic z);
        longint unsigned p, q, r;
        p = longint'(a) * longint'(b);
        if (d == 0) begin
            o = 16'hFFFF; v = 1'b0; z = 1'b1;
        end else begin
            q = p / d;
            r = p % d;
            if (rnd != 0 && 2 * r >= d) q = q + 1;
            z = 1'b0;
            if (q > 65535) begin
                o = 16'hFFFF; v = 1'b1;
            end else begin
                o = q[15:0]; v = 1'b0;
            end
        end
    endfunction

    // Issues one operation with a single-cycle start pulse; scrambles the operand
    // inputs right after the accepting edge and reports what both instances produced.
    task automatic run_op(input logic [15:0] a, b, d, output int lat,
                          output logic [15:0] o0, o1, output logic v0, v1, z0, z1,
                          output logic dn1, output logic bsy_at_done, output logic bsy_early);
        @(negedge clk);
        rv = a; d2 = b; d1 = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bsy_early = busy0;
        rv = 16'($urandom); d2 = 16'($urandom); d1 = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                lat = n;
                break;
            end
        end
        o0 = out0; o1 = out1; v0 = ovf0; v1 = ovf1; z0 = dz0; z1 = dz1;
        dn1 = done1; bsy_at_done = busy0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out0, busy0, done0, ovf0, dz0} !== 20'h0) begin
            fails++;
            $display("FAIL reset_r0: out=%h busy=%b done=%b ovf=%b dz=%b, required all 0",
                     out0, busy0, done0, ovf0, dz0);
        end
        tests++;
        if ({out1, busy1, done1, ovf1, dz1} !== 20'h0) begin
            fails++;
            $display("FAIL reset_r1: out=%h busy=%b done=%b ovf=%b dz=%b, required all 0",
                     out1, busy1, done1, ovf1, dz1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [15:0] va[6] = '{16'd5040, 16'd7, 16'd5, 16'd65535, 16'd65535, 16'd100};
        logic [15:0] vb[6] = '{16'd2,    16'd1, 16'd1, 16'd65535, 16'd65535, 16'd3};
        logic [15:0] vd[6] = '{16'd1,    16'd2, 16'd4, 16'd1,     16'd65535, 16'd0};
        logic [15:0] e0[6] = '{16'd10080, 16'd3, 16'd1, 16'hFFFF, 16'd65535, 16'hFFFF};
        logic [15:0] e1[6] = '{16'd10080, 16'd4, 16'd1, 16'hFFFF, 16'd65535, 16'hFFFF};
        logic        eo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ez[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          el[6] = '{34, 34, 34, 34, 34, 2};
        int lat;
        logic [15:0] o0, o1;
        logic v0, v1, z0, z1, dn1, bd, be;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vd[i], lat, o0, o1, v0, v1, z0, z1, dn1, bd, be);
            tests++;
            if (lat !== el[i] || dn1 !== 1'b1) begin
                fails++;
                $display("FAIL dir%0d_latency: done after edge %0d (r1 done=%b), required %0d",
                         i, lat, dn1, el[i]);
            end
            tests++;
            if ({o0, v0, z0} !== {e0[i], eo[i], ez[i]}) begin
                fails++;
                $display("FAIL dir%0d_r0: out=%0d ovf=%b dz=%b, required out=%0d ovf=%b dz=%b",
                         i, o0, v0, z0, e0[i], eo[i], ez[i]);
            end
            tests++;
            if ({o1, v1, z1} !== {e1[i], eo[i], ez[i]}) begin
                fails++;
                $display("FAIL dir%0d_r1: out=%0d ovf=%b dz=%b, required out=%0d ovf=%b dz=%b",
                         i, o1, v1, z1, e1[i], eo[i], ez[i]);
            end
            tests++;
            if (be !== 1'b1 || bd !== 1'b0) begin
                fails++;
                $display("FAIL dir%0d_busy: after start=%b at done=%b, required 1 then 0",
                         i, be, bd);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b, d, x0, x1, o0, o1;
        logic xv0, xv1, xz0, xz1, v0, v1, z0, z1, dn1, bd, be;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 16'd0;
                1:       d = 16'($urandom_range(1, 15));
                2:       d = 16'($urandom);
                default: d = (a == 0) ? 16'd1 : a;
            endcase
            if (i % 4 == 3) b = 16'($urandom_range(0, 9));
            model(a, b, d, 0, x0, xv0, xz0);
            model(a, b, d, 1, x1, xv1, xz1);
            run_op(a, b, d, lat, o0, o1, v0, v1, z0, z1, dn1, bd, be);
            tests++;
            if (lat !== ((d == 0) ? 2 : 34)) begin
                fails++;
                $display("FAIL rnd%0d_latency: %0d, required %0d", i, lat, (d == 0) ? 2 : 34);
            end
            tests++;
            if ({o0, v0, z0} !== {x0, xv0, xz0}) begin
                fails++;
                $display("FAIL rnd%0d_r0 %0d*%0d/%0d: out=%0d ovf=%b dz=%b, required %0d %b %b",
                         i, a, b, d, o0, v0, z0, x0, xv0, xz0);
            end
            tests++;
            if ({o1, v1, z1} !== {x1, xv1, xz1}) begin
                fails++;
                $display("FAIL rnd%0d_r1 %0d*%0d/%0d: out=%0d ovf=%b dz=%b, required %0d %b %b",
                         i, a, b, d, o1, v1, z1, x1, xv1, xz1);
            end
        end
    endtask

    // Start pulse mid-operation must neither alter the result nor queue a second run
    task automatic test_busy_ignore;
        int lat = -1;
        int extra = 0;
        @(negedge clk);
        rv = 16'd300; d2 = 16'd7; d1 = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            if (n == 10) begin rv = 16'd1; d2 = 16'd1; d1 = 16'd1; start = 1'b1; end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done0) lat = n;
        end
        tests++;
        if (lat !== 34 || out0 !== 16'd420) begin
            fails++;
            $display("FAIL busy_ignore: lat=%0d out=%0d, required lat=34 out=420", lat, out0);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_ignore_queued: %0d busy/done cycles after, required 0", extra);
        end
    endtask

    task automatic test_reset_midop;
        int saw = 0;
        int lat;
        logic [15:0] o0, o1;
        logic v0, v1, z0, z1, dn1, bd, be;
        @(negedge clk);
        rv = 16'd5040; d2 = 16'd2; d1 = 16'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            if (n == 10) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done0) saw++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++;
        if ({out0, busy0, done0, out1, busy1} !== 34'h0 || saw !== 0) begin
            fails++;
            $display("FAIL midop_reset: out=%0d busy=%b done=%b out1=%0d busy1=%b early_done=%0d, required 0",
                     out0, busy0, done0, out1, busy1, saw);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) saw++;
        end
        tests++;
        if (saw !== 0) begin
            fails++;
            $display("FAIL midop_no_done: %0d busy/done cycles after reset, required 0", saw);
        end
        run_op(16'd9, 16'd9, 16'd3, lat, o0, o1, v0, v1, z0, z1, dn1, bd, be);
        tests++;
        if (lat !== 34 || o0 !== 16'd27 || o1 !== 16'd27) begin
            fails++;
            $display("FAIL midop_after: lat=%0d out=%0d out1=%0d, required 34 27 27", lat, o0, o1);
        end
    endtask

    task automatic test_back_to_back;
        int when[$];
        int outs[$];
        @(negedge clk);
        rv = 16'd10; d2 = 16'd10; d1 = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 200 && when.size() < 3; n++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                when.push_back(n);
                outs.push_back(int'(out0));
            end
        end
        start = 1'b0;
        tests++;
        if (when.size() !== 3) begin
            fails++;
            $display("FAIL b2b_count: %0d done pulses, required 3", when.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (when[k] !== 34 + 35 * k || outs[k] !== 20) begin
                    fails++;
                    $display("FAIL b2b_op%0d: done at edge %0d out=%0d, required edge %0d out=20",
                             k, when[k], outs[k], 34 + 35 * k);
                end
            end
        end
        repeat (40) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
